// File: rtl/muladd_issue_ctl.sv
// Issue/collect controller for the 20-cycle multiply-add pipeline.
// Credits reserve a response slot per issued op so returns never overflow.
module muladd_issue_ctl #(
  parameter int DEPTH  = 32,
  parameter int HTID_W = 7
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic [63:0]       i_req_a,
  input  logic [63:0]       i_req_b,
  input  logic [63:0]       i_req_c,
  input  logic [HTID_W-1:0] i_req_htId,
  output logic              o_pipe_vld,
  output logic [63:0]       o_pipe_a,
  output logic [63:0]       o_pipe_b,
  output logic [63:0]       o_pipe_c,
  output logic [HTID_W-1:0] o_pipe_htId,
  input  logic              i_pipe_vld,
  input  logic [63:0]       i_pipe_res,
  input  logic [HTID_W-1:0] i_pipe_htId,
  output logic              o_rsp_vld,
  input  logic              i_rsp_rdy,
  output logic [63:0]       o_rsp_res,
  output logic [HTID_W-1:0] o_rsp_htId,
  output logic              o_idle,
  output logic              o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [63:0]       res;
    logic [HTID_W-1:0] ht;
  } ent_t;

  ent_t mem [DEPTH];

  logic [CW-1:0] inflight;
  logic [CW-1:0] pipe_out;
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_nxt;
  logic [CW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic          req_hs;
  logic          rsp_hs;
  logic          spurious;
  logic          overflow;
  logic          push;
  logic          full;
  logic          head_load;
  ent_t          head;
  ent_t          incoming;

  assign o_req_rdy = inflight < FULL_CNT;
  assign o_idle    = inflight == '0;

  assign count     = wr_ptr - rd_ptr;
  assign full      = count == FULL_CNT;
  assign o_rsp_vld = count != '0;

  assign req_hs = i_req_vld & o_req_rdy;
  assign rsp_hs = o_rsp_vld & i_rsp_rdy;

  assign spurious = i_pipe_vld & (pipe_out == '0);
  assign overflow = i_pipe_vld & full & ~rsp_hs;
  assign push     = i_pipe_vld & ~spurious & ~overflow;

  assign incoming = '{res: i_pipe_res, ht: i_pipe_htId};

  assign wr_nxt = wr_ptr + CW'(push);
  assign rd_nxt = rd_ptr + CW'(rsp_hs);

  // Next head may be the entry being written this very cycle.
  assign head_load = wr_nxt != rd_nxt;

  always_comb begin
    head = mem[rd_nxt[AW-1:0]];
    if (push && (rd_nxt == wr_ptr)) begin
      head = incoming;
    end
  end

  always_ff @(posedge ck) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= incoming;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_rsp_res  <= '0;
      o_rsp_htId <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (head_load) begin
        o_rsp_res  <= head.res;
        o_rsp_htId <= head.ht;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      unique case (1'b1)
        (req_hs & ~rsp_hs): inflight <= inflight + 1'b1;
        (~req_hs & rsp_hs): inflight <= inflight - 1'b1;
        default:            inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      pipe_out <= '0;
    end else begin
      unique case (1'b1)
        (o_pipe_vld & ~i_pipe_vld): pipe_out <= pipe_out + 1'b1;
        (~o_pipe_vld & push):       pipe_out <= pipe_out - 1'b1;
        (~o_pipe_vld & overflow):   pipe_out <= pipe_out - 1'b1;
        default:                    pipe_out <= pipe_out;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      o_pipe_vld  <= 1'b0;
      o_pipe_a    <= '0;
      o_pipe_b    <= '0;
      o_pipe_c    <= '0;
      o_pipe_htId <= '0;
    end else begin
      o_pipe_vld <= req_hs;
      if (req_hs) begin
        o_pipe_a    <= i_req_a;
        o_pipe_b    <= i_req_b;
        o_pipe_c    <= i_req_c;
        o_pipe_htId <= i_req_htId;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if (spurious | overflow) begin
      o_err <= 1'b1;
    end
  end

endmodule
